// File: rtl/dout_pkg.sv
// Shared constants, types and slot/header helpers for the multi-lane ADC data-output transmitter.
package dout_pkg;

  localparam int NUM_CHANNELS = 8;
  localparam int NUM_LANES    = 4;
  localparam int SAMPLE_BITS  = 24;
  localparam int HEADER_BITS  = 8;
  localparam int SLOT_BITS    = 32;
  localparam int LANE_BITS    = 2 * SLOT_BITS;

  typedef logic signed [23:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRDY  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // Header carries the zero-based channel index so the receiver can check slot order.
  function automatic logic [HEADER_BITS-1:0] build_header(input logic [2:0] idx);
    return {1'b0, idx, 4'b0000};
  endfunction

  function automatic logic [SLOT_BITS-1:0] build_slot(input logic [2:0] idx, input sample_t sample);
    return {build_header(idx), sample};
  endfunction

endpackage

// File: rtl/dout_lane_serializer.sv
// One data lane: parallel-load 64-bit register shifted out MSB first.
module dout_lane_serializer
  import dout_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 load,
  input  logic                 shift,
  input  logic [LANE_BITS-1:0] data_i,
  output logic                 bit_o
);

  logic [LANE_BITS-1:0] sreg_d;
  logic [LANE_BITS-1:0] sreg_q;

  // Zeros shift in behind the data, so the lane idles low once all 64 bits are gone.
  always_comb begin
    if (load) begin
      sreg_d = data_i;
    end else if (shift) begin
      sreg_d = {sreg_q[LANE_BITS-2:0], 1'b0};
    end else begin
      sreg_d = sreg_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign bit_o = sreg_q[LANE_BITS-1];

endmodule

// File: rtl/dout_writer.sv
// ADC-side transmitter for the DoutReader link: periodic frames of eight 32-bit slots
// serialized over four lanes with a data-ready strobe and a divided data clock.
module dout_writer
  import dout_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int FRAME_PERIOD = 8192
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [23:0] ch1_i,
  input  logic [23:0] ch2_i,
  input  logic [23:0] ch3_i,
  input  logic [23:0] ch4_i,
  input  logic [23:0] ch5_i,
  input  logic [23:0] ch6_i,
  input  logic [23:0] ch7_i,
  input  logic [23:0] ch8_i,
  output logic        drdy_o,
  output logic        dclk_o,
  output logic [3:0]  dout_o,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam int TW = $clog2(FRAME_PERIOD);
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_PERIOD - 1);
  localparam logic [PW-1:0] PH_LAST    = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HIGH    = PW'(CLK_DIV);
  localparam logic [5:0]    BIT_LAST   = 6'd63;

  if (CLK_DIV < 1 || FRAME_PERIOD < 2 * CLK_DIV * 66) begin : g_param_check
    $error("dout_writer: need CLK_DIV >= 1 and FRAME_PERIOD >= 2*CLK_DIV*66");
  end

  state_t        state_d, state_q;
  logic [TW-1:0] timer_d, timer_q;
  logic [PW-1:0] ph_d, ph_q;
  logic [5:0]    bit_d, bit_q;
  logic          drdy_d, drdy_q;
  logic          dclk_d, dclk_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;
  logic          wrap_s;
  logic          load_s;
  logic          shift_s;
  logic [PW-1:0] ph_inc_s;
  logic [23:0]   ch_s [NUM_CHANNELS];

  assign wrap_s   = (timer_q == TIMER_LAST);
  assign ph_inc_s = ph_q + PW'(1);

  assign ch_s[0] = ch1_i;
  assign ch_s[1] = ch2_i;
  assign ch_s[2] = ch3_i;
  assign ch_s[3] = ch4_i;
  assign ch_s[4] = ch5_i;
  assign ch_s[5] = ch6_i;
  assign ch_s[6] = ch7_i;
  assign ch_s[7] = ch8_i;

  // Free-running frame timer; FRAME_PERIOD need not be a power of two.
  always_comb begin
    if (wrap_s) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Frame sequencer: one phase counter paces both the DRDY window and every dclk period.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    drdy_d  = drdy_q;
    dclk_d  = dclk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load_s  = 1'b0;
    shift_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (wrap_s && enable_i) begin
          state_d = DRDY;
          ph_d    = '0;
          bit_d   = 6'd0;
          drdy_d  = 1'b1;
          dclk_d  = 1'b0;
          busy_d  = 1'b1;
          load_s  = 1'b1;
        end else begin
          drdy_d = 1'b0;
          dclk_d = 1'b0;
          busy_d = 1'b0;
        end
      end
      DRDY: begin
        if (ph_q == PH_LAST) begin
          state_d = SHIFT;
          ph_d    = '0;
          drdy_d  = 1'b0;
        end else begin
          ph_d = ph_inc_s;
        end
      end
      SHIFT: begin
        if (ph_q == PH_LAST) begin
          // End of a high phase: dclk falls and the lanes advance together.
          ph_d    = '0;
          dclk_d  = 1'b0;
          shift_s = 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end else begin
          ph_d   = ph_inc_s;
          dclk_d = (ph_inc_s >= PH_HIGH);
        end
      end
      default: begin
        state_d = IDLE;
        ph_d    = '0;
        bit_d   = 6'd0;
        drdy_d  = 1'b0;
        dclk_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      ph_q    <= '0;
      bit_q   <= 6'd0;
      drdy_q  <= 1'b0;
      dclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      drdy_q  <= drdy_d;
      dclk_q  <= dclk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [LANE_BITS-1:0] lane_word_s;
    assign lane_word_s = {build_slot(3'(2 * k), ch_s[2 * k]),
                          build_slot(3'(2 * k + 1), ch_s[2 * k + 1])};
    dout_lane_serializer u_ser (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .load    (load_s),
      .shift   (shift_s),
      .data_i  (lane_word_s),
      .bit_o   (dout_o[k])
    );
  end

  assign drdy_o       = drdy_q;
  assign dclk_o       = dclk_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule
